// File: rtl/lc4_alu_seq.sv
// Registered LC4 ALU with a valid/ready handshake. Single-cycle ops resolve on
// the accept edge; MUL/DIV/MOD iterate on a shared MSB-first shift datapath.
module lc4_alu_seq #(
    parameter int WIDTH       = 16,
    parameter int BITS_PER_CY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [15:0]      i_insn,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_r1data,
    input  logic [WIDTH-1:0] i_r2data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div0
);

    localparam int STEPS = WIDTH / BITS_PER_CY;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_MASK = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] acc_reg, shf_reg, opb_reg, result_reg;
    logic [CNT_W-1:0] count_reg;
    logic             is_mul_reg, is_div_reg, div0_reg;

    // ---------------- decode ----------------
    logic [3:0] opcode;
    logic       op_mul, op_div, op_mod, rt_zero, div_by_zero, start_iter, accept, last_step;

    assign opcode      = i_insn[15:12];
    assign op_mul      = (opcode == 4'b0001) && (i_insn[5:3] == 3'b001);
    assign op_div      = (opcode == 4'b0001) && (i_insn[5:3] == 3'b011);
    assign op_mod      = (opcode == 4'b1010) && (i_insn[5:4] == 2'b11);
    assign rt_zero     = (i_r2data == '0);
    assign div_by_zero = (op_div || op_mod) && rt_zero;
    assign start_iter  = op_mul || ((op_div || op_mod) && !rt_zero);
    assign accept      = i_valid && o_ready;
    assign last_step   = (count_reg == CNT_W'(STEPS - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = start_iter ? ITER : DONE;
            ITER:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_reg == IDLE);
        o_valid = (state_reg == DONE);
        o_div0  = (state_reg == DONE) && div0_reg;
    end

    assign o_result = result_reg;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] imm5_s, imm6_s, imm7_s, imm7_u, imm9_s, imm11_s, uimm8, pc_inc;
    logic [WIDTH-1:0] cmp_b, cmp_value, alu_value;
    logic [3:0]       shamt;
    logic             cmp_gt;

    assign imm5_s  = {{(WIDTH-5){i_insn[4]}},  i_insn[4:0]};
    assign imm6_s  = {{(WIDTH-6){i_insn[5]}},  i_insn[5:0]};
    assign imm7_s  = {{(WIDTH-7){i_insn[6]}},  i_insn[6:0]};
    assign imm7_u  = WIDTH'(i_insn[6:0]);
    assign imm9_s  = {{(WIDTH-9){i_insn[8]}},  i_insn[8:0]};
    assign imm11_s = {{(WIDTH-11){i_insn[10]}}, i_insn[10:0]};
    assign uimm8   = WIDTH'(i_insn[7:0]);
    assign shamt   = i_insn[3:0];
    assign pc_inc  = i_pc + ONE;

    // insn[8] selects immediate operand, insn[7] selects unsigned compare
    assign cmp_b     = i_insn[8] ? (i_insn[7] ? imm7_u : imm7_s) : i_r2data;
    assign cmp_gt    = i_insn[7] ? (i_r1data > cmp_b) : ($signed(i_r1data) > $signed(cmp_b));
    assign cmp_value = (i_r1data == cmp_b) ? '0 : (cmp_gt ? ONE : '1);

    always_comb begin
        alu_value = '0;
        case (opcode)
            4'b0000: alu_value = pc_inc + imm9_s;
            4'b0001: begin
                if (i_insn[5]) alu_value = i_r1data + imm5_s;
                else if (i_insn[4:3] == 2'b00) alu_value = i_r1data + i_r2data;
                else if (i_insn[4:3] == 2'b10) alu_value = i_r1data + ~i_r2data + ONE;
            end
            4'b0010: alu_value = cmp_value;
            4'b0100: alu_value = i_insn[11] ? ((i_pc & MSB_MASK) | (imm11_s << 4)) : i_r1data;
            4'b0101: begin
                if (i_insn[5]) alu_value = i_r1data & imm5_s;
                else begin
                    case (i_insn[4:3])
                        2'b00:   alu_value = i_r1data & i_r2data;
                        2'b01:   alu_value = ~i_r1data;
                        2'b10:   alu_value = i_r1data | i_r2data;
                        default: alu_value = i_r1data ^ i_r2data;
                    endcase
                end
            end
            4'b0110, 4'b0111: alu_value = i_r1data + imm6_s;
            4'b1000: alu_value = i_r1data;
            4'b1001: alu_value = imm9_s;
            4'b1010: begin
                case (i_insn[5:4])
                    2'b00:   alu_value = i_r1data << shamt;
                    2'b01:   alu_value = $signed(i_r1data) >>> shamt;
                    2'b10:   alu_value = i_r1data >> shamt;
                    default: alu_value = '0;
                endcase
            end
            4'b1100: alu_value = i_insn[11] ? (pc_inc + imm11_s) : i_r1data;
            4'b1101: alu_value = WIDTH'({i_insn[7:0], i_r1data[7:0]});
            4'b1111: alu_value = MSB_MASK | uimm8;
            default: alu_value = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // shf_reg shifts left MSB-first: multiplier bits for MUL, dividend bits
    // (replaced by quotient bits) for DIV/MOD. acc_reg is product or remainder.
    logic [WIDTH-1:0] acc_step, shf_step;
    logic [WIDTH:0]   trial;
    logic             take;

    always_comb begin
        acc_step = acc_reg;
        shf_step = shf_reg;
        trial    = '0;
        take     = 1'b0;
        for (int step = 0; step < BITS_PER_CY; step++) begin
            trial = {acc_step, shf_step[WIDTH-1]};
            take  = !is_mul_reg && (trial >= {1'b0, opb_reg});
            if (is_mul_reg)
                acc_step = {acc_step[WIDTH-2:0], 1'b0} + (shf_step[WIDTH-1] ? opb_reg : '0);
            else if (take)
                acc_step = trial[WIDTH-1:0] - opb_reg;
            else
                acc_step = trial[WIDTH-1:0];
            shf_step = {shf_step[WIDTH-2:0], take};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            shf_reg    <= '0;
            opb_reg    <= '0;
            count_reg  <= '0;
            is_mul_reg <= 1'b0;
            is_div_reg <= 1'b0;
            div0_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg    <= '0;
                        shf_reg    <= i_r1data;
                        opb_reg    <= i_r2data;
                        count_reg  <= '0;
                        is_mul_reg <= op_mul;
                        is_div_reg <= op_div;
                        div0_reg   <= div_by_zero;
                        if (!start_iter) result_reg <= div_by_zero ? '0 : alu_value;
                    end
                end
                ITER: begin
                    acc_reg   <= acc_step;
                    shf_reg   <= shf_step;
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_step) result_reg <= is_div_reg ? shf_step : acc_step;
                end
                default: ;
            endcase
        end
    end

endmodule
